// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin two-requester 8-bit add/sub unit sharing one CLA adder.
// Define ADDER_ARBITER_SUB_EN to enable subtraction (two's complement via EXEC + INC).
module adder_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic       req1_valid,
   output logic       req0_ready,
   output logic       req1_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic       req0_sub,
   input  logic       req1_sub,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_id,
   output logic       busy
);
`ifdef ADDER_ARBITER_SUB_EN
   localparam logic SUB_EN = 1'b1;
`else
   localparam logic SUB_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, EXEC, INC, RESP} state_t;
   state_t state;
   logic [7:0] acc, a_r, b_r, op_a, op_b, sum;
   logic sub_r, id_r, last, gnt;
   // gnt is the index that would win this cycle; last starts at 1 so req0 wins first
   assign gnt = (req0_valid & req1_valid) ? ~last : req1_valid;
   assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~gnt;
   assign req1_ready = ~rst & (state == IDLE) & req1_valid & gnt;
   assign op_a = (state == INC) ? acc : a_r;
   assign op_b = (state == INC) ? 8'h01 : b_r ^ {8{sub_r}};
   assign rsp_valid = (state == RESP);
   assign rsp_data = acc;
   assign rsp_id = id_r;
   assign busy = (state != IDLE);
   add8 u_add (.a(op_a), .b(op_b), .s(sum));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc <= '0;
         a_r <= '0;
         b_r <= '0;
         sub_r <= 1'b0;
         id_r <= 1'b0;
         last <= 1'b1;
      end else begin
         case (state)
            IDLE: if (req0_ready | req1_ready) begin
               a_r <= gnt ? req1_a : req0_a;
               b_r <= gnt ? req1_b : req0_b;
               sub_r <= SUB_EN & (gnt ? req1_sub : req0_sub);
               id_r <= gnt;
               last <= gnt;
               state <= EXEC;
            end
            EXEC: begin
               acc <= sum;
               state <= sub_r ? INC : RESP;
            end
            INC: begin
               acc <= sum;
               state <= RESP;
            end
            RESP: if (rsp_ready) state <= IDLE;
         endcase
      end
   end
endmodule

module add8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] s
);
   logic [3:0] g, p;
   logic c4;
   assign g = a[3:0] & b[3:0];
   assign p = a[3:0] ^ b[3:0];
   // low-nibble group carry, carry-in tied to 0
   assign c4 = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
   cla4 u_lo (.a(a[3:0]), .b(b[3:0]), .ci(1'b0), .s(s[3:0]));
   cla4 u_hi (.a(a[7:4]), .b(b[7:4]), .ci(c4), .s(s[7:4]));
endmodule

module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s
);
   logic [3:0] g, p, c;
   assign g = a & b;
   assign p = a ^ b;
   assign c[0] = ci;
   assign c[1] = g[0] | p[0] & ci;
   assign c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & ci;
   assign c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & ci;
   assign s = p ^ c;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random transactions checked against an arithmetic reference model.
module tb_adder_arbiter;
   logic clk = 1'b0, rst;
   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic req0_sub, req1_sub, rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_data;
   int n_chk = 0, n_fail = 0;
   bit last_id = 1'b1;
`ifdef ADDER_ARBITER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif
   always #5 clk = ~clk;
   adder_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_sub(req0_sub), .req1_sub(req1_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
      int r;
      r = (SUB_EN && sub) ? int'(a) - int'(b) : int'(a) + int'(b);
      return 8'((r + 256) % 256);
   endfunction
   // Called at posedge+1 with the DUT idle; returns the granted requester.
   task automatic txn(input bit v0, input bit v1, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [7:0] a1, input logic [7:0] b1, input bit s0, input bit s1,
                      input int hold, output bit got);
      bit exp_g;
      logic [7:0] exp_d;
      int exp_lat, lat, k;
      req0_valid = v0; req1_valid = v1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      req0_sub = s0; req1_sub = s1; rsp_ready = 1'b0;
      exp_g = (v0 && v1) ? !last_id : v1;
      exp_d = exp_g ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
      exp_lat = (SUB_EN && (exp_g ? s1 : s0)) ? 3 : 2;
      k = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("hs_timeout", k < 20, 1);
      chk("one_ready", 32'(req0_ready) + 32'(req1_ready), 1);
      chk("grant", req1_ready, exp_g);
      got = req1_ready;
      last_id = exp_g;
      @(posedge clk); #1;
      req0_a = 8'($urandom); req0_b = 8'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      req0_sub = 1'($urandom); req1_sub = 1'($urandom);
      lat = 1;
      forever begin
         @(negedge clk);
         chk("busy_ready", {req0_ready, req1_ready}, 0);
         chk("busy", busy, 1);
         if (rsp_valid || lat >= 8) break;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_id", rsp_id, exp_g);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, exp_d);
         chk("hold_id", rsp_id, exp_g);
         chk("hold_ready", {req0_ready, req1_ready}, 0);
      end
      rsp_ready = 1'b1;
      #1 chk("resp_ready", {req0_ready, req1_ready}, 0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("idle_busy", busy, 0);
   endtask
   initial begin
      bit g;
      bit [3:0] order;
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_sub = 1'b0; req1_sub = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      txn(1, 0, 8'h3C, 8'h05, 8'h00, 8'h00, 0, 0, 0, g);
      txn(0, 1, 8'h00, 8'h00, 8'h00, 8'h01, 0, 1, 0, g);
      chk("sub_wrap", rsp_data, SUB_EN ? 8'hFF : 8'h01);
      txn(1, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 0, 0, g);
      txn(1, 0, 8'h81, 8'h22, 8'h00, 8'h00, 0, 0, 5, g);
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; last_id = 1'b1;
      for (int i = 0; i < 4; i++) begin
         txn(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 0, g);
         order[3 - i] = g;
      end
      chk("grant_order", order, 4'b0101);
      req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 8'hFF; req0_b = 8'h01; req0_sub = 1'b0;
      @(negedge clk);
      chk("mid_hs", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0; last_id = 1'b1;
      chk("mid_busy", busy, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      chk("mid_first_grant", {req0_ready, req1_ready}, 2'b10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_no_rsp", rsp_valid, 0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
         bit v0, v1;
         v0 = 1'($urandom); v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1'b1;
         txn(v0, v1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), g);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports req0_valid / req1_valid  in  1  requester N has an operation pending.
REQ-004 SHALL have ports req0_ready / req1_ready  out  1  requester N's operation accepted this cycle.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  in  8  operands.
REQ-006 SHALL have ports req0_sub / req1_sub  in  1  1 = subtract (a - b); 0 = add (a + b).
REQ-007 SHALL have port rsp_valid  out  1  result available.
REQ-008 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-009 SHALL have port rsp_data  out  8  result, modulo 256.
REQ-010 SHALL have port rsp_id  out  1  requester index that owns rsp_data.
REQ-011 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL instantiate exactly one 8-bit adder instance (two cascaded 4-bit CLAs, carry-in 0, no carry-out) and route every arithmetic operation through it.
REQ-013 SHALL implement FSM states IDLE, EXEC, INC, RESP.
REQ-014 IDLE: reqN_ready is driven high combinationally only when reqN is granted; handshake = reqN_valid & reqN_ready.
REQ-015 On a handshake, latch a, b, sub and id, then go to EXEC.
REQ-016 Arbitration is round-robin: if both requesters are valid, grant the requester not granted last; if only one is valid, grant it.
REQ-017 The last-grant register updates only on a handshake.
REQ-018 EXEC: acc <= adder(a, sub ? ~b : b); go to INC if sub, else go to RESP.
REQ-019 INC: acc <= adder(acc, 8'h01); go to RESP.
REQ-020 RESP: rsp_valid = 1, rsp_data = acc, rsp_id = latched id; all outputs stay stable until rsp_ready.
REQ-021 RESP with rsp_ready = 1: go to IDLE. A new request can be accepted no earlier than the following cycle.
REQ-022 Both reqN_ready SHALL be 0 in every state except IDLE.
REQ-023 Latency from handshake edge to rsp_valid: add = 2 cycles; sub = 3 cycles.
REQ-024 Overflow wraps modulo 256 and no carry or flag is reported (e.g. 0xFF + 0x01 = 0x00; 0x00 - 0x01 = 0xFF).
REQ-025 Request inputs that change while the block is busy SHALL NOT affect the operation in flight.

Reset
REQ-026 When rst is high at a clock edge: state = IDLE, acc = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0, last-grant = 1 (so req0 wins the first contention).
REQ-027 Reset asserted during EXEC, INC or RESP SHALL abort the operation with no response emitted.
REQ-028 Both reqN_ready SHALL be 0 while rst is high.

Configuration
REQ-029 Macro ADDER_ARBITER_SUB_EN enables subtraction.
REQ-030 With ADDER_ARBITER_SUB_EN defined: behaviour as REQ-018/019.
REQ-031 Without ADDER_ARBITER_SUB_EN: reqN_sub is ignored, every operation is an add, INC is unreachable, and add latency is unchanged.

Verification
REQ-032 Single add: req0 a=0x3C, b=0x05, sub=0 -> rsp_valid 2 cycles after handshake, rsp_data=0x41, rsp_id=0.
REQ-033 Subtract with wrap (macro on): req1 a=0x00, b=0x01, sub=1 -> rsp_data=0xFF, rsp_id=1, latency 3 cycles. With the macro off, same stimulus -> rsp_data=0x01.
REQ-034 Contention: both valid continuously, after reset -> grant order 0,1,0,1; exactly one ready per handshake cycle.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_data/rsp_id stable, both readys 0, and the request is accepted only on the cycle after rsp_ready=1.
REQ-036 Reset mid-op: rst asserted in EXEC of 0xFF+0x01 -> no rsp_valid; next cycle busy=0 and req0 is granted first.
